// File: rtl/cfg_init_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cfg_init_loader_pkg                                        |
// | Description : Shared constants for the serial config loader: CRC-8       |
// |               polynomial, FSM state encoding, default sync word and a    |
// |               single-step CRC helper.                                    |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cfg_init_loader_pkg;

  // CRC-8 polynomial x^8 + x^2 + x + 1 (implicit x^8 term dropped)
  localparam logic [7:0] c_CRC8_POLY = 8'h07;

  // Frame start pattern used when the instantiator does not override it
  localparam logic [7:0] c_SYNC_WORD_DEFAULT = 8'hA5;

  // Loader FSM encoding
  localparam logic [1:0] c_ST_HUNT  = 2'd0;
  localparam logic [1:0] c_ST_LOAD  = 2'd1;
  localparam logic [1:0] c_ST_CHECK = 2'd2;
  localparam logic [1:0] c_ST_IDLE  = 2'd3;

  // One bit of the MSB-first serial CRC-8 LFSR
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
    logic w_fb;
    w_fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (w_fb ? c_CRC8_POLY : 8'h00);
  endfunction

endpackage : cfg_init_loader_pkg
`default_nettype wire

// File: rtl/cfg_init_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cfg_init_loader_if                                         |
// | Description : Serial-in / config-out bundle of the init loader.          |
// |               master : drives init_in, init_en, reinit                   |
// |               slave  : the loader; drives cfg_out, cfg_valid, busy,      |
// |                        crc_err, commit_cnt, err_cnt                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface cfg_init_loader_if #(
  parameter int CFG_LEN = 22,
  parameter int CNT_W   = 8
);

  logic               init_in;
  logic               init_en;
  logic               reinit;
  logic [CFG_LEN-1:0] cfg_out;
  logic               cfg_valid;
  logic               busy;
  logic               crc_err;
  logic [CNT_W-1:0]   commit_cnt;
  logic [CNT_W-1:0]   err_cnt;

  modport master (
    output init_in, init_en, reinit,
    input  cfg_out, cfg_valid, busy, crc_err, commit_cnt, err_cnt
  );

  modport slave (
    input  init_in, init_en, reinit,
    output cfg_out, cfg_valid, busy, crc_err, commit_cnt, err_cnt
  );

endinterface : cfg_init_loader_if
`default_nettype wire

// File: rtl/cfg_init_loader_crc8_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : crc8_serial                                                |
// | Description : Bit-serial CRC-8 (poly 0x07, init 0x00), MSB-first.        |
// |   clk   in  core clock                                                   |
// |   rst   in  asynchronous active-high reset                               |
// |   i_clr in  synchronous clear to 0x00 (wins over i_en)                   |
// |   i_en  in  advance the LFSR by one bit                                  |
// |   i_din in  serial data bit                                              |
// |   o_crc out current remainder                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module crc8_serial
  import cfg_init_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_din,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= 8'h00;
    end else if (i_clr) begin
      r_crc <= 8'h00;
    end else if (i_en) begin
      r_crc <= crc8_next(r_crc, i_din);
    end
  end

  assign o_crc = r_crc;

endmodule : crc8_serial
`default_nettype wire

// File: rtl/cfg_init_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cfg_init_loader                                            |
// | Description : Framed serial configuration loader. Hunts for SYNC_WORD,   |
// |               shifts in CFG_LEN payload bits (first bit ends in bit 0),  |
// |               optionally checks an 8-bit CRC trailer, and only then      |
// |               commits the payload to cfg_out. Previous config stays live |
// |               until the next good frame.                                 |
// |   clk          in   core clock                                           |
// |   rst          in   asynchronous active-high reset                       |
// |   bus (slave)  init_in/init_en/reinit in; cfg_out, cfg_valid, busy,      |
// |                crc_err, commit_cnt, err_cnt out                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cfg_init_loader
  import cfg_init_loader_pkg::*;
#(
  parameter int                  CFG_LEN   = 22,
  parameter int                  SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = c_SYNC_WORD_DEFAULT,
  parameter bit                  CRC_EN    = 1'b1,
  parameter int                  CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  cfg_init_loader_if.slave bus
);

  // Bit counter covers both the payload and the 8-bit trailer
  localparam int c_BCNT_W = (CFG_LEN > 8) ? $clog2(CFG_LEN) : 3;

  logic [1:0]          r_state;
  logic [SYNC_LEN-1:0] r_window;
  logic [CFG_LEN-1:0]  r_shift;
  logic [6:0]          r_rx_crc;   // first 7 trailer bits; the 8th is compared live
  logic [c_BCNT_W-1:0] r_bit_cnt;
  logic                r_commit_pend;
  logic [CFG_LEN-1:0]  r_cfg;
  logic                r_cfg_valid;
  logic                r_crc_err;
  logic [CNT_W-1:0]    r_commit_cnt;
  logic [CNT_W-1:0]    r_err_cnt;

  logic [SYNC_LEN-1:0] w_window_nxt;
  logic [7:0]          w_rx_crc_full;
  logic [7:0]          w_crc;
  logic                w_crc_clr;
  logic                w_crc_en;
  logic                w_last_pay;
  logic                w_last_crc;

  assign w_window_nxt  = {r_window[SYNC_LEN-2:0], bus.init_in};
  assign w_rx_crc_full = {r_rx_crc, bus.init_in};
  assign w_last_pay    = (r_bit_cnt == c_BCNT_W'(CFG_LEN - 1));
  assign w_last_crc    = (r_bit_cnt == c_BCNT_W'(7));

  // Holding the CRC at zero for all of HUNT guarantees a clean start on LOAD entry
  assign w_crc_clr = (r_state == c_ST_HUNT) || bus.reinit;
  assign w_crc_en  = (r_state == c_ST_LOAD) && bus.init_en;

  crc8_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_din (bus.init_in),
    .o_crc (w_crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_ST_HUNT;
      r_window      <= '0;
      r_shift       <= '0;
      r_rx_crc      <= '0;
      r_bit_cnt     <= '0;
      r_commit_pend <= 1'b0;
      r_cfg         <= '0;
      r_cfg_valid   <= 1'b0;
      r_crc_err     <= 1'b0;
      r_commit_cnt  <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_commit_pend <= 1'b0;
      r_crc_err     <= 1'b0;

      // Commit lands one edge after the final bit; r_shift is frozen in IDLE
      if (r_commit_pend) begin
        r_cfg       <= r_shift;
        r_cfg_valid <= 1'b1;
        if (r_commit_cnt != '1) begin
          r_commit_cnt <= r_commit_cnt + 1'b1;
        end
      end

      if (bus.reinit) begin
        // Aborts a partial frame; a final bit sampled together with reinit is dropped
        r_state  <= c_ST_HUNT;
        r_window <= '0;
      end else begin
        case (r_state)
          c_ST_HUNT: begin
            if (bus.init_en) begin
              r_window <= w_window_nxt;
              if (w_window_nxt == SYNC_WORD) begin
                r_state   <= c_ST_LOAD;
                r_bit_cnt <= '0;
              end
            end
          end

          c_ST_LOAD: begin
            if (bus.init_en) begin
              r_shift   <= {bus.init_in, r_shift[CFG_LEN-1:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_pay) begin
                r_bit_cnt <= '0;
                if (CRC_EN) begin
                  r_state <= c_ST_CHECK;
                end else begin
                  r_state       <= c_ST_IDLE;
                  r_commit_pend <= 1'b1;
                end
              end
            end
          end

          c_ST_CHECK: begin
            if (bus.init_en) begin
              r_rx_crc  <= w_rx_crc_full[6:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_crc) begin
                r_bit_cnt <= '0;
                if (w_rx_crc_full == w_crc) begin
                  r_state       <= c_ST_IDLE;
                  r_commit_pend <= 1'b1;
                end else begin
                  r_state   <= c_ST_HUNT;
                  r_window  <= '0;
                  r_crc_err <= 1'b1;
                  if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                  end
                end
              end
            end
          end

          default: begin
            // IDLE: serial input ignored until reinit
          end
        endcase
      end
    end
  end

  assign bus.cfg_out    = r_cfg;
  assign bus.cfg_valid  = r_cfg_valid;
  assign bus.busy       = (r_state == c_ST_LOAD) || (r_state == c_ST_CHECK);
  assign bus.crc_err    = r_crc_err;
  assign bus.commit_cnt = r_commit_cnt;
  assign bus.err_cnt    = r_err_cnt;

endmodule : cfg_init_loader
`default_nettype wire

// File: tb/tb_cfg_init_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cfg_init_loader                                         |
// | Description : Self-checking bench for cfg_init_loader. DUT A has the CRC |
// |               trailer enabled, DUT B has it disabled. Expected commit /  |
// |               CRC-error events are queued when a frame is sent and       |
// |               matched when the DUT reports them.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cfg_init_loader;

  typedef struct {
    int          dut;
    bit          err;
    logic [21:0] cfg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   tgt    = 0;
  bit   gap_en = 1'b0;
  exp_t sb[$];
  logic [7:0] prev_cc_a = '0;
  logic [7:0] prev_cc_b = '0;

  cfg_init_loader_if #(.CFG_LEN(22), .CNT_W(8)) bus_a ();
  cfg_init_loader_if #(.CFG_LEN(22), .CNT_W(8)) bus_b ();

  cfg_init_loader #(.CFG_LEN(22), .SYNC_LEN(8), .SYNC_WORD(8'hA5), .CRC_EN(1'b1), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  cfg_init_loader #(.CFG_LEN(22), .SYNC_LEN(8), .SYNC_WORD(8'hA5), .CRC_EN(1'b0), .CNT_W(8))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference CRC: remainder of M(x)*x^8 mod (x^8+x^2+x+1), first bit sent = highest degree
  function automatic logic [7:0] ref_crc(input logic [21:0] p);
    logic [29:0] r;
    r = '0;
    for (int i = 0; i < 22; i++) r[29-i] = p[i];
    for (int i = 29; i >= 8; i--) if (r[i]) r[i-:9] = r[i-:9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic expect_evt(input int dut, input bit err, input logic [21:0] cfg);
    exp_t e;
    e.dut = dut; e.err = err; e.cfg = cfg;
    sb.push_back(e);
  endtask

  task automatic sb_event(input int dut, input bit err, input logic [21:0] cfg);
    exp_t e;
    check_eq("sb_pending", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("sb_dut", 64'(dut), 64'(e.dut));
      check_eq("sb_kind", 64'(err), 64'(e.err));
      check_eq("sb_cfg", 64'(cfg), 64'(e.cfg));
    end
  endtask

  // Output monitor: turns crc_err pulses and commit counter steps into events
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.crc_err) sb_event(0, 1'b1, bus_a.cfg_out);
      if (bus_a.commit_cnt > prev_cc_a) sb_event(0, 1'b0, bus_a.cfg_out);
      if (bus_b.crc_err) sb_event(1, 1'b1, bus_b.cfg_out);
      if (bus_b.commit_cnt > prev_cc_b) sb_event(1, 1'b0, bus_b.cfg_out);
    end
    prev_cc_a = bus_a.commit_cnt;
    prev_cc_b = bus_b.commit_cnt;
  end

  task automatic drive(input logic d, input logic en, input logic ri);
    if (tgt == 0) begin
      bus_a.init_in = d; bus_a.init_en = en; bus_a.reinit = ri;
    end else begin
      bus_b.init_in = d; bus_b.init_en = en; bus_b.reinit = ri;
    end
  endtask

  // Unqualified gap cycles carry the inverted bit so accidental sampling corrupts the frame
  task automatic send_bit(input logic b, input logic ri = 1'b0);
    if (gap_en) begin
      drive(~b, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(b, 1'b1, ri);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_payload(input logic [21:0] p, input int n);
    for (int i = 0; i < n; i++) send_bit(p[i]);
  endtask

  task automatic send_frame(input logic [21:0] p, input logic [7:0] crc, input bit ri_last = 1'b0);
    send_bits(16'h00A5, 8);
    send_payload(p, 22);
    for (int i = 7; i >= 0; i--) send_bit(crc[i], ri_last && (i == 0));
  endtask

  task automatic pulse_reinit();
    drive(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    #1;
    check_eq(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [21:0] p;
    bus_a.init_in = 1'b0; bus_a.init_en = 1'b0; bus_a.reinit = 1'b0;
    bus_b.init_in = 1'b0; bus_b.init_en = 1'b0; bus_b.reinit = 1'b0;
    #12;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check_eq("rst_cfg_out", 64'(bus_a.cfg_out), 64'd0);
    check_eq("rst_cfg_valid", 64'(bus_a.cfg_valid), 64'd0);
    check_eq("rst_busy", 64'(bus_a.busy), 64'd0);
    check_eq("rst_crc_err", 64'(bus_a.crc_err), 64'd0);
    check_eq("rst_commit_cnt", 64'(bus_a.commit_cnt), 64'd0);
    check_eq("rst_err_cnt", 64'(bus_a.err_cnt), 64'd0);

    // Zero payload, zero CRC; commit one cycle after the final bit
    tgt = 0;
    expect_evt(0, 1'b0, 22'h0);
    send_bits(16'h00A5, 8);
    check_eq("load_busy", 64'(bus_a.busy), 64'd1);
    send_payload(22'h0, 22);
    send_bits(16'h0000, 8);
    check_eq("zero_valid_lat0", 64'(bus_a.cfg_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("zero_valid_lat1", 64'(bus_a.cfg_valid), 64'd1);
    check_eq("zero_commit_cnt", 64'(bus_a.commit_cnt), 64'd1);
    check_eq("zero_busy_idle", 64'(bus_a.busy), 64'd0);
    wait_drain("zero_drain");
    check_eq("zero_err_cnt", 64'(bus_a.err_cnt), 64'd0);

    // Single-bit payload, good trailer
    do_reset();
    expect_evt(0, 1'b0, 22'h200000);
    send_frame(22'h200000, 8'h07);
    wait_drain("one_drain");
    check_eq("one_cfg", 64'(bus_a.cfg_out), 64'h200000);
    check_eq("one_commit_cnt", 64'(bus_a.commit_cnt), 64'd1);

    // Same payload, bad trailer: error pulse, config held, back in HUNT
    pulse_reinit();
    expect_evt(0, 1'b1, 22'h200000);
    send_frame(22'h200000, 8'h06);
    check_eq("bad_pulse_hi", 64'(bus_a.crc_err), 64'd1);
    check_eq("bad_err_cnt", 64'(bus_a.err_cnt), 64'd1);
    @(posedge clk); #1;
    check_eq("bad_pulse_lo", 64'(bus_a.crc_err), 64'd0);
    check_eq("bad_cfg_held", 64'(bus_a.cfg_out), 64'h200000);
    check_eq("bad_hunt_busy", 64'(bus_a.busy), 64'd0);
    check_eq("bad_commit_cnt", 64'(bus_a.commit_cnt), 64'd1);
    wait_drain("bad_drain");
    // Still hunting: a good frame without reinit must commit
    p = 22'h0A5A5A;
    expect_evt(0, 1'b0, p);
    send_frame(p, ref_crc(p));
    wait_drain("rehunt_drain");
    check_eq("rehunt_commit_cnt", 64'(bus_a.commit_cnt), 64'd2);

    // Noise with the sync word embedded at offset 1, then with 50% qualifier gaps
    for (int g = 0; g < 2; g++) begin
      do_reset();
      gap_en = (g == 1);
      expect_evt(0, 1'b0, 22'h0);
      send_bits(16'b1_1010_0101, 9);
      send_payload(22'h0, 22);
      send_bits(16'h0000, 8);
      wait_drain("noise_drain");
      check_eq("noise_commit_cnt", 64'(bus_a.commit_cnt), 64'd1);
      check_eq("noise_cfg_valid", 64'(bus_a.cfg_valid), 64'd1);
    end

    // Random payloads under qualifier gaps
    for (int k = 0; k < 3; k++) begin
      p = 22'($urandom);
      pulse_reinit();
      expect_evt(0, 1'b0, p);
      send_frame(p, ref_crc(p));
      wait_drain("rnd_drain");
      check_eq("rnd_cfg", 64'(bus_a.cfg_out), 64'(p));
    end
    gap_en = 1'b0;

    // reinit aborts a partial frame; resend commits
    do_reset();
    p = 22'h2AB3C1;
    expect_evt(0, 1'b0, p);
    send_frame(p, ref_crc(p));
    wait_drain("first_drain");
    pulse_reinit();
    send_bits(16'h00A5, 8);
    send_payload(22'h155555, 10);
    pulse_reinit();
    check_eq("abort_busy", 64'(bus_a.busy), 64'd0);
    send_payload(22'h3FFFFF, 12);
    send_bits(16'h00FF, 8);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_cfg_held", 64'(bus_a.cfg_out), 64'(p));
    check_eq("abort_commit_cnt", 64'(bus_a.commit_cnt), 64'd1);
    pulse_reinit();
    expect_evt(0, 1'b0, 22'h155555);
    send_frame(22'h155555, ref_crc(22'h155555));
    wait_drain("resend_drain");
    check_eq("resend_cfg", 64'(bus_a.cfg_out), 64'h155555);
    check_eq("resend_commit_cnt", 64'(bus_a.commit_cnt), 64'd2);

    // reinit together with the final trailer bit: no commit
    pulse_reinit();
    send_frame(22'h000123, ref_crc(22'h000123), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("ri_last_cfg", 64'(bus_a.cfg_out), 64'h155555);
    check_eq("ri_last_commit_cnt", 64'(bus_a.commit_cnt), 64'd2);
    check_eq("ri_last_err_cnt", 64'(bus_a.err_cnt), 64'd0);

    // No-trailer variant: commit straight after the payload
    tgt = 1;
    expect_evt(1, 1'b0, 22'h155555);
    send_bits(16'h00A5, 8);
    send_payload(22'h155555, 22);
    check_eq("nocrc_valid_lat0", 64'(bus_b.cfg_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("nocrc_valid_lat1", 64'(bus_b.cfg_valid), 64'd1);
    check_eq("nocrc_cfg", 64'(bus_b.cfg_out), 64'h155555);
    check_eq("nocrc_commit_cnt", 64'(bus_b.commit_cnt), 64'd1);
    wait_drain("nocrc_drain");

    // Asynchronous reset mid-payload clears everything without waiting for a clock
    pulse_reinit();
    send_bits(16'h00A5, 8);
    send_payload(22'h0ABCDE, 11);
    check_eq("mid_busy", 64'(bus_b.busy), 64'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("arst_cfg_out", 64'(bus_b.cfg_out), 64'd0);
    check_eq("arst_cfg_valid", 64'(bus_b.cfg_valid), 64'd0);
    check_eq("arst_busy", 64'(bus_b.busy), 64'd0);
    check_eq("arst_commit_cnt", 64'(bus_b.commit_cnt), 64'd0);
    check_eq("arst_a_cfg_valid", 64'(bus_a.cfg_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    check_eq("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_cfg_init_loader
`default_nettype wire
